inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit_pkg.sv | 24 ++
 rtl/inst_fetch_unit_if.sv | 32 +++
 rtl/inst_fetch_unit_fifo.sv | 86 ++++++++
 rtl/inst_fetch_unit.sv | 118 +++++++++++
 tb/tb_inst_fetch_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared processor types for the instruction fetch path: address and
// instruction widths, plus the packed entry kept in the fetch buffer.
package ProcessorDefs;

    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] InstAddr;
    typedef logic [INST_WIDTH-1:0] Inst;

    // One buffered fetch: the word and the address it was fetched from.
    typedef struct packed {
        InstAddr pc;
        Inst     inst;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_WIDTH = $bits(fetch_entry_t);

    // Sequential fetch address; natural 32-bit overflow wraps 0xFFFF_FFFC to 0.
    function automatic InstAddr next_inst_addr(input InstAddr pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundles the cache-side and decode-side handshakes of the fetch unit.
// master = fetch unit, slave = the cache/pipeline environment.
interface inst_fetch_unit_if;
    import ProcessorDefs::*;

    // Instruction cache core port
    InstAddr o_inst_addr;
    logic    o_inst_re;
    logic    i_inst_busy;
    Inst     i_inst_data;

    // Pipeline redirect
    logic    i_redirect;
    InstAddr i_redirect_pc;

    // Decode port
    logic    o_valid;
    Inst     o_inst;
    InstAddr o_pc;
    logic    i_ready;

    modport master (
        output o_inst_addr, o_inst_re, o_valid, o_inst, o_pc,
        input  i_inst_busy, i_inst_data, i_redirect, i_redirect_pc, i_ready
    );

    modport slave (
        input  o_inst_addr, o_inst_re, o_valid, o_inst, o_pc,
        output i_inst_busy, i_inst_data, i_redirect, i_redirect_pc, i_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Small power-of-two FIFO holding fetched instructions between the cache
// and decode. Flush wins over push and pop; push is ignored when full and
// pop is ignored when empty so the occupancy can never over/underflow.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == {CW{1'b0}});
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Next storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers, cleared asynchronously so no stale word survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: walks the pc through the instruction cache, one
// request per cycle when the cache is not busy, and queues completed words
// for decode. A redirect restarts fetching at a new word-aligned target and
// throws away everything buffered or in flight.
module inst_fetch_unit import ProcessorDefs::*; #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    inst_fetch_unit_if.master  bus
);

    localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam InstAddr       START_PC = {RESET_PC[31:2], 2'b00};

    // Fetch FSM encoding: FETCH and WAIT both request, FULL parks the port.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    InstAddr      pc_q, pc_d;
    logic         inst_re_q, inst_re_d;

    logic         complete_s;
    logic         push_s;
    logic         pop_s;
    logic         full_s;
    logic         empty_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_after_s;
    fetch_entry_t entry_in_s;
    fetch_entry_t head_s;

    // A request completes when it is presented and the cache is not stalling.
    // Redirect discards that completion and blocks any pop in the same cycle.
    assign complete_s = inst_re_q & ~bus.i_inst_busy;
    assign push_s     = complete_s & ~bus.i_redirect & ~full_s;
    assign pop_s      = ~empty_s & bus.i_ready & ~bus.i_redirect;
    assign entry_in_s = {pc_q, bus.i_inst_data};

    fetch_fifo #(
        .WIDTH (FETCH_ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (i_clock),
        .rst_n (i_reset),
        .flush (bus.i_redirect),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_in_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Occupancy the buffer will hold after this cycle's push and pop.
    always_comb begin
        count_after_s = count_s;
        case ({push_s, pop_s})
            2'b10:   count_after_s = count_s + CW'(1);
            2'b01:   count_after_s = count_s - CW'(1);
            default: count_after_s = count_s;
        endcase
    end

    // Next fetch state, pc and request; the request is a flop so decode-side
    // ready and cache busy never reach the cache port combinationally.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_re_d = inst_re_q;
        if (bus.i_redirect) begin
            state_d   = ST_FETCH;
            pc_d      = {bus.i_redirect_pc[31:2], 2'b00};
            inst_re_d = 1'b1;
        end else begin
            if (push_s) begin
                pc_d = next_inst_addr(pc_q);
            end else begin
                pc_d = pc_q;
            end
            if (count_after_s == DEPTH_C) begin
                state_d = ST_FULL;
            end else begin
                case (state_q)
                    ST_FETCH, ST_WAIT: state_d = (inst_re_q & bus.i_inst_busy) ? ST_WAIT : ST_FETCH;
                    ST_FULL:           state_d = ST_FETCH;
                    default:           state_d = ST_FETCH;
                endcase
            end
            inst_re_d = (state_d != ST_FULL);
        end
    end

    // Fetch state registers; reset parks the request low at the start pc.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= START_PC;
            inst_re_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_re_q <= inst_re_d;
        end
    end

    assign bus.o_inst_addr = pc_q;
    assign bus.o_inst_re   = inst_re_q;
    assign bus.o_valid     = ~empty_s;
    assign bus.o_inst      = head_s.inst;
    assign bus.o_pc        = head_s.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit (RESET_PC=0x100, FIFO_DEPTH=2).
// A queue-based model predicts request, address and buffer head every cycle;
// directed literal checks pin the model at the interesting points.
module tb_inst_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic clk;
    logic rst;
    logic chk_en;
    int   total;
    int   bad;

    // model state
    logic [31:0] exp_pc;
    logic        exp_re;
    logic [63:0] q[$];

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Cache contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    assign bus.i_inst_data = mem_word(bus.o_inst_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_pc = RPC;
        exp_re = 1'b0;
    endtask

    // Applies the rules for one rising edge using the inputs present before it.
    task automatic model_step();
        logic fire;
        if (!rst) begin
            model_reset();
        end else if (bus.i_redirect) begin
            q.delete();
            exp_pc = {bus.i_redirect_pc[31:2], 2'b00};
            exp_re = 1'b1;
        end else begin
            fire = exp_re && !bus.i_inst_busy;
            if (q.size() != 0 && bus.i_ready) q.delete(0);
            if (fire) begin
                q.push_back({exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            exp_re = (q.size() < DEPTH);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_re", 32'(bus.o_inst_re), 32'(exp_re));
            chk("m_addr", bus.o_inst_addr, exp_pc);
            chk("m_valid", 32'(bus.o_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_pc", bus.o_pc, q[0][63:32]);
                chk("m_inst", bus.o_inst, q[0][31:0]);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        bus.i_inst_busy   = 1'b0;
        bus.i_ready       = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        model_reset();
        #1 rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #2;
        chk("rst_re", 32'(bus.o_inst_re), 32'h0);
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_addr", bus.o_inst_addr, 32'h0000_0100);
        tick(); tick();

        // reset release: consecutive addresses
        rst = 1'b1;
        tick();
        chk("rel_re", 32'(bus.o_inst_re), 32'h1);
        chk("rel_a0", bus.o_inst_addr, 32'h0000_0100);
        tick();
        chk("rel_a1", bus.o_inst_addr, 32'h0000_0104);
        chk("rel_pc", bus.o_pc, 32'h0000_0100);
        tick();
        chk("rel_a2", bus.o_inst_addr, 32'h0000_0108);

        // stall at 0x200 for three cycles
        bus.i_ready = 1'b0;
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0200;
        tick();
        bus.i_redirect = 1'b0;
        chk("stl_flush", 32'(bus.o_valid), 32'h0);
        bus.i_inst_busy = 1'b1;
        chk("stl_a0", bus.o_inst_addr, 32'h0000_0200);
        tick();
        chk("stl_a1", bus.o_inst_addr, 32'h0000_0200);
        tick();
        chk("stl_a2", bus.o_inst_addr, 32'h0000_0200);
        tick();
        bus.i_inst_busy = 1'b0;
        chk("stl_a3", bus.o_inst_addr, 32'h0000_0200);
        chk("stl_nov", 32'(bus.o_valid), 32'h0);
        tick();
        chk("stl_next", bus.o_inst_addr, 32'h0000_0204);
        chk("stl_pc", bus.o_pc, 32'h0000_0200);
        bus.i_inst_busy = 1'b1; bus.i_ready = 1'b1;
        tick();
        chk("stl_one", 32'(bus.o_valid), 32'h0);

        // backpressure into FULL and out again
        bus.i_inst_busy = 1'b0; bus.i_ready = 1'b0;
        tick();
        chk("bp_re1", 32'(bus.o_inst_re), 32'h1);
        tick();
        chk("bp_full", 32'(bus.o_inst_re), 32'h0);
        chk("bp_head", bus.o_pc, 32'h0000_0204);
        tick();
        chk("bp_hold", 32'(bus.o_inst_re), 32'h0);
        chk("bp_addr", bus.o_inst_addr, 32'h0000_020C);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk("bp_resume", 32'(bus.o_inst_re), 32'h1);
        chk("bp_pop", bus.o_pc, 32'h0000_0208);
        tick();
        chk("bp_full2", 32'(bus.o_inst_re), 32'h0);

        // redirect with two buffered entries, unaligned target
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0403;
        tick();
        bus.i_redirect = 1'b0;
        chk("rd_valid", 32'(bus.o_valid), 32'h0);
        chk("rd_addr", bus.o_inst_addr, 32'h0000_0400);
        chk("rd_re", 32'(bus.o_inst_re), 32'h1);
        bus.i_ready = 1'b1;
        tick();
        chk("rd_pc", bus.o_pc, 32'h0000_0400);

        // address wrap; redirect also drops the completion at 0x404
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.i_redirect = 1'b0;
        chk("wr_drop", 32'(bus.o_valid), 32'h0);
        tick();
        chk("wr_a", bus.o_inst_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_zero", bus.o_inst_addr, 32'h0000_0000);
        chk("wr_pc", bus.o_pc, 32'hFFFF_FFFC);
        tick();
        chk("wr_pc0", bus.o_pc, 32'h0000_0000);

        // mixed busy/ready/redirect pattern, checked by the model
        for (int i = 0; i < 60; i++) begin
            bus.i_inst_busy   = ((i % 5) == 2) || ((i % 7) == 3);
            bus.i_ready       = ((i % 4) != 1) && (i < 30 || (i % 6) < 3);
            bus.i_redirect    = (i == 17) || (i == 38);
            bus.i_redirect_pc = 32'h0000_3001 + 32'(i) * 32'd64;
            tick();
        end
        bus.i_redirect = 1'b0;

        // asynchronous reset in the middle of a stall
        bus.i_inst_busy = 1'b1;
        tick(); tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("ar_re", 32'(bus.o_inst_re), 32'h0);
        chk("ar_valid", 32'(bus.o_valid), 32'h0);
        chk("ar_addr", bus.o_inst_addr, 32'h0000_0100);
        tick();
        chk("ar_hold", 32'(bus.o_inst_re), 32'h0);
        bus.i_inst_busy = 1'b0;
        rst = 1'b1;
        tick();
        chk("ar_rel_re", 32'(bus.o_inst_re), 32'h1);
        chk("ar_rel_addr", bus.o_inst_addr, 32'h0000_0100);
        tick(); tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
